// File: rtl/pipearch_bram_pkg.sv
// Shared types and constants for the pipearch BRAM responder.
package pipearch_bram_pkg;

   typedef enum logic {
      STATE_IDLE  = 1'b0,
      STATE_CLEAR = 1'b1
   } t_clearstate;

   localparam int unsigned DEFAULT_WIDTH = 512;

   // clear_reg field positions
   localparam int unsigned CLR_BASE_LSB = 0;
   localparam int unsigned CLR_BASE_MSB = 15;
   localparam int unsigned CLR_CNT_LSB  = 16;
   localparam int unsigned CLR_CNT_MSB  = 31;

endpackage

// File: rtl/pipearch_bram_responder_bram_sdp.sv
// Simple dual-port read-first line array: one write port, one read port
// with a sampled read stage and a resettable output register (2-cycle latency).
module bram_sdp
   import pipearch_bram_pkg::*;
#(
   parameter int unsigned WIDTH      = DEFAULT_WIDTH,
   parameter int unsigned LOG2_DEPTH = 10
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_we,
   input  logic [LOG2_DEPTH-1:0] i_waddr,
   input  logic [WIDTH-1:0]      i_wdata,
   input  logic                  i_re,
   input  logic [LOG2_DEPTH-1:0] i_raddr,
   output logic [WIDTH-1:0]      o_rdata
);

   logic [WIDTH-1:0] r_mem [0:(1<<LOG2_DEPTH)-1];
   logic [WIDTH-1:0] r_rd1;
   logic [WIDTH-1:0] r_rd2;

   // Write port: commit at the end of the request cycle.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read stage 1: sample the line before any same-cycle write lands (read-first).
   always_ff @(posedge i_clk) begin
      if (i_re) begin
         r_rd1 <= r_mem[i_raddr];
      end
   end

   // Read stage 2: output register, cleared by reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rd2 <= '0;
      end else begin
         r_rd2 <= r_rd1;
      end
   end

   assign o_rdata = r_rd2;

endmodule

// File: rtl/pipearch_bram_responder.sv
// BRAM responder: pipelined reads (2-cycle latency), single-cycle writes and a
// range-clear engine with a start/done handshake.
// Optional macro PIPEARCH_BRAM_FORWARD_EN: a read returns the data of a write
// committing to the same line in the same cycle (otherwise read-first).
module pipearch_bram_responder
   import pipearch_bram_pkg::*;
#(
   parameter int unsigned WIDTH      = DEFAULT_WIDTH,
   parameter int unsigned LOG2_DEPTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             re,
   input  logic [15:0]      raddr,
   output logic             rvalid,
   output logic [WIDTH-1:0] rdata,
   input  logic             we,
   input  logic [15:0]      waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             clear_start,
   input  logic [31:0]      clear_reg,
   output logic             clear_busy,
   output logic             clear_done,
   output logic             wr_dropped
);

   t_clearstate           r_state;
   t_clearstate           w_state_nxt;
   logic                  w_load;
   logic                  w_done_nxt;
   logic [LOG2_DEPTH-1:0] r_ptr;
   logic [15:0]           r_remain;
   logic                  r_done;
   logic                  r_drop;
   logic                  r_rv1;
   logic                  r_rv2;
   logic                  w_busy;
   logic [LOG2_DEPTH-1:0] w_raddr;
   logic [LOG2_DEPTH-1:0] w_base;
   logic [15:0]           w_count;
   logic                  w_mem_we;
   logic [LOG2_DEPTH-1:0] w_mem_waddr;
   logic [WIDTH-1:0]      w_mem_wdata;
   logic [WIDTH-1:0]      w_sdp_rdata;
   logic                  w_unused;

   assign w_raddr = raddr[LOG2_DEPTH-1:0];
   assign w_base  = clear_reg[CLR_BASE_LSB +: LOG2_DEPTH];
   assign w_count = clear_reg[CLR_CNT_MSB:CLR_CNT_LSB];
   assign w_busy  = (r_state == STATE_CLEAR);

   // High address bits alias modulo depth and are intentionally ignored.
   assign w_unused = &{1'b0, raddr[15:LOG2_DEPTH], waddr[15:LOG2_DEPTH],
                       clear_reg[CLR_BASE_MSB:LOG2_DEPTH]};

   // Clear FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= STATE_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Clear FSM next-state: load on start, finish after the last zero write.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         STATE_IDLE: begin
            if (clear_start) begin
               if (w_count == 16'd0) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_load      = 1'b1;
                  w_state_nxt = STATE_CLEAR;
               end
            end
         end
         STATE_CLEAR: begin
            if (r_remain == 16'd1) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = STATE_IDLE;
            end
         end
         default: w_state_nxt = STATE_IDLE;
      endcase
   end

   // Clear engine pointer/count and registered done/dropped pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_done <= 1'b0;
         r_drop <= 1'b0;
      end else begin
         r_done <= w_done_nxt;
         r_drop <= w_busy & we;
         if (w_load) begin
            r_ptr    <= w_base;
            r_remain <= w_count;
         end else if (w_busy) begin
            r_ptr    <= r_ptr + 1'b1;
            r_remain <= r_remain - 16'd1;
         end
      end
   end

   // Write-port mux: the clear engine owns the port while busy; reset blocks writes.
   always_comb begin
      w_mem_we    = (w_busy | we) & ~reset;
      w_mem_waddr = waddr[LOG2_DEPTH-1:0];
      w_mem_wdata = wdata;
      if (w_busy) begin
         w_mem_waddr = r_ptr;
         w_mem_wdata = '0;
      end
   end

   // Read-valid pipeline, two stages matching the array latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rv1 <= 1'b0;
         r_rv2 <= 1'b0;
      end else begin
         r_rv1 <= re;
         r_rv2 <= r_rv1;
      end
   end

   bram_sdp #(
      .WIDTH      (WIDTH),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_bram (
      .i_clk   (clk),
      .i_reset (reset),
      .i_we    (w_mem_we),
      .i_waddr (w_mem_waddr),
      .i_wdata (w_mem_wdata),
      .i_re    (re),
      .i_raddr (w_raddr),
      .o_rdata (w_sdp_rdata)
   );

`ifdef PIPEARCH_BRAM_FORWARD_EN
   logic             w_fwd_hit;
   logic             r_fwd1;
   logic             r_fwd2;
   logic [WIDTH-1:0] r_fwd_d1;
   logic [WIDTH-1:0] r_fwd_d2;

   assign w_fwd_hit = re & w_mem_we & (w_mem_waddr == w_raddr);

   // Bypass pipeline: carry same-cycle write data alongside the array read.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fwd1 <= 1'b0;
         r_fwd2 <= 1'b0;
      end else begin
         r_fwd1 <= w_fwd_hit;
         r_fwd2 <= r_fwd1;
      end
      r_fwd_d1 <= w_mem_wdata;
      r_fwd_d2 <= r_fwd_d1;
   end

   assign rdata = r_fwd2 ? r_fwd_d2 : w_sdp_rdata;
`else
   assign rdata = w_sdp_rdata;
`endif

   assign rvalid     = r_rv2;
   assign clear_busy = w_busy;
   assign clear_done = r_done;
   assign wr_dropped = r_drop;

endmodule

// File: tb/tb_pipearch_bram_responder.sv
// Self-checking bench for pipearch_bram_responder (table vectors + scoreboard).
module tb_pipearch_bram_responder;

   localparam int unsigned W = 512;
   localparam int unsigned L = 10;
   localparam int unsigned D = 1024;
`ifdef PIPEARCH_BRAM_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          re;
   logic [15:0]   raddr;
   logic          rvalid;
   logic [W-1:0]  rdata;
   logic          we;
   logic [15:0]   waddr;
   logic [W-1:0]  wdata;
   logic          clear_start;
   logic [31:0]   clear_reg;
   logic          clear_busy;
   logic          clear_done;
   logic          wr_dropped;

   pipearch_bram_responder #(.WIDTH(W), .LOG2_DEPTH(L)) dut (
      .clk         (clk),
      .reset       (reset),
      .re          (re),
      .raddr       (raddr),
      .rvalid      (rvalid),
      .rdata       (rdata),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .clear_start (clear_start),
      .clear_reg   (clear_reg),
      .clear_busy  (clear_busy),
      .clear_done  (clear_done),
      .wr_dropped  (wr_dropped)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] mdl [0:D-1];

   typedef struct {
      int unsigned  due;
      logic [W-1:0] d;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      bit           r;
      logic [15:0]  ra;
      bit           w;
      logic [15:0]  wa;
      logic [W-1:0] wd;
      logic [W-1:0] e;
   } vec_t;
   vec_t tbl [12];

   function automatic logic [W-1:0] initv(int unsigned i);
      return {16{32'hC0DE_0000 | i}};
   endfunction

   function automatic logic [W-1:0] pat(logic [7:0] b);
      return {64{b}};
   endfunction

   task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic chkb(string name, logic act, logic req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // One cycle: check read outputs mid-cycle against the scoreboard, then advance.
   task automatic tick();
      @(negedge clk);
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         chkb("rvalid", rvalid, 1'b1);
         chk("rdata", rdata, sbq[0].d);
         void'(sbq.pop_front());
      end else begin
         chkb("rvalid_idle", rvalid, 1'b0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit r, logic [15:0] ra, bit w, logic [15:0] wa,
                        logic [W-1:0] wd, logic [W-1:0] e);
      re = r; raddr = ra; we = w; waddr = wa; wdata = wd;
      if (r) sbq.push_back('{cyc + 2, e});
      if (w) mdl[wa[L-1:0]] = wd;
      tick();
      re = 1'b0; we = 1'b0;
   endtask

   task automatic rd(logic [L-1:0] a);
      drive(1'b1, {6'd0, a}, 1'b0, 16'd0, '0, mdl[a]);
   endtask

   task automatic start_clear(logic [15:0] base, logic [15:0] cnt);
      clear_start = 1'b1;
      clear_reg   = {cnt, base};
      tick();
      clear_start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{1'b0, 16'd0,      1'b1, 16'd5,      pat(8'hA5), '0};
      tbl[1]  = '{1'b0, 16'd0,      1'b0, 16'd0,      '0,         '0};
      tbl[2]  = '{1'b1, 16'd5,      1'b0, 16'd0,      '0,         pat(8'hA5)};
      tbl[3]  = '{1'b0, 16'd0,      1'b1, 16'd7,      512'h99,    '0};
      tbl[4]  = '{1'b0, 16'd0,      1'b0, 16'd0,      '0,         '0};
      tbl[5]  = '{1'b1, 16'd7,      1'b1, 16'd7,      512'h1234,  FWD ? 512'h1234 : 512'h99};
      tbl[6]  = '{1'b1, 16'd7,      1'b0, 16'd0,      '0,         512'h1234};
      tbl[7]  = '{1'b0, 16'd0,      1'b1, 16'h0405,   pat(8'h3C), '0};
      tbl[8]  = '{1'b1, 16'hFC05,   1'b0, 16'd0,      '0,         pat(8'h3C)};
      tbl[9]  = '{1'b1, 16'd9,      1'b0, 16'd0,      '0,         initv(9)};
      tbl[10] = '{1'b0, 16'd0,      1'b1, 16'd9,      pat(8'h77), '0};
      tbl[11] = '{1'b1, 16'd9,      1'b0, 16'd0,      '0,         pat(8'h77)};

      reset = 1'b1; re = 1'b0; raddr = '0; we = 1'b0; waddr = '0; wdata = '0;
      clear_start = 1'b0; clear_reg = '0;
      @(posedge clk); #1;
      tick(); tick();
      chkb("reset_rvalid", rvalid, 1'b0);
      chk("reset_rdata", rdata, '0);
      chkb("reset_busy", clear_busy, 1'b0);
      chkb("reset_done", clear_done, 1'b0);
      chkb("reset_dropped", wr_dropped, 1'b0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 32; i++) drive(1'b0, 16'd0, 1'b1, 16'(i), initv(i), '0);
      for (int i = 1016; i < 1024; i++) drive(1'b0, 16'd0, 1'b1, 16'(i), initv(i), '0);

      for (int i = 0; i < 12; i++)
         drive(tbl[i].r, tbl[i].ra, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].e);

      // back-to-back reads of lines 0..15
      for (int i = 0; i < 16; i++) rd(L'(i));
      tick(); tick();

      // wrapping clear base 1022 count 4, with a dropped write and a read in flight
      begin
         int unsigned s;
         s = cyc;
         start_clear(16'd1022, 16'd4);
         for (int k = 1; k <= 5; k++) begin
            chkb("clr_busy", clear_busy, (k <= 4));
            chkb("clr_done", clear_done, (k == 5));
            chkb("clr_dropped", wr_dropped, (k == 3));
            chkb("clr_cycle", (cyc == s + k), 1'b1);
            if (k == 1) begin
               re = 1'b1; raddr = 16'd2;
               sbq.push_back('{cyc + 2, mdl[2]});
            end
            if (k == 2) begin
               we = 1'b1; waddr = 16'd3; wdata = pat(8'hEE);
            end
            tick();
            re = 1'b0; we = 1'b0;
         end
      end
      mdl[1022] = '0; mdl[1023] = '0; mdl[0] = '0; mdl[1] = '0;
      rd(10'd1021); rd(10'd1022); rd(10'd1023); rd(10'd0); rd(10'd1); rd(10'd2); rd(10'd3);
      tick(); tick();

      // zero-count clear
      chkb("z_busy_start", clear_busy, 1'b0);
      start_clear(16'd100, 16'd0);
      chkb("z_done", clear_done, 1'b1);
      chkb("z_busy", clear_busy, 1'b0);
      tick();
      chkb("z_done_end", clear_done, 1'b0);
      chkb("z_busy_end", clear_busy, 1'b0);

      // reset in the second cycle of a count-8 clear
      start_clear(16'd10, 16'd8);
      chkb("rm_busy", clear_busy, 1'b1);
      re = 1'b1; raddr = 16'd20;
      tick();
      re = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chkb("rm_busy_rst", clear_busy, 1'b0);
      chkb("rm_done_rst", clear_done, 1'b0);
      chkb("rm_rvalid_rst", rvalid, 1'b0);
      chk("rm_rdata_rst", rdata, '0);
      chkb("rm_drop_rst", wr_dropped, 1'b0);
      for (int k = 0; k < 12; k++) begin
         tick();
         chkb("rm_no_done", clear_done, 1'b0);
      end
      mdl[10] = '0;
      rd(10'd10); rd(10'd11); rd(10'd17);
      tick(); tick();

      // a normal clear afterwards
      start_clear(16'd20, 16'd3);
      for (int k = 1; k <= 4; k++) begin
         chkb("pc_busy", clear_busy, (k <= 3));
         chkb("pc_done", clear_done, (k == 4));
         tick();
      end
      mdl[20] = '0; mdl[21] = '0; mdl[22] = '0;
      for (int i = 19; i <= 23; i++) rd(L'(i));

      for (int i = 0; i < 10 && sbq.size() > 0; i++) tick();
      if (sbq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d reads outstanding, required 0", sbq.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
